i2c_codec_target: RTL
=====================

# i2c_codec_target

I2C target (responder) that models the WM8731-style codec control port. It sits at the far end of the I2C bus driven by the team's I2C initiator and decodes the initiator's 3-byte write frames (device address, register/data-MSB, data-LSB). It holds a 16-entry × 9-bit shadow register file that the bench or on-chip logic can read back. One instance replaces the physical codec in simulation; the same block can also sit on-chip to snoop or mirror codec configuration.

## Interface
Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address; the write address byte is 0x34.
- SYNC_STAGES, 2, synchronizer depth on SCL/SDA (allowed values 2..3).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- scl  in  1  I2C clock from the bus (asynchronous).
- sda_in  in  1  I2C data as seen on the bus (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- busy  out  1  high from a detected START until the next detected STOP.
- wr_valid  out  1  one-clk pulse per completed register write.
- wr_addr  out  7  register address of the last write.
- wr_data  out  9  data of the last write.
- rd_addr  in  4  shadow register read index.
- rd_data  out  9  registered read data.
- nack_count  out  8  saturating count of NACKs issued by this target.

## Operation
- Synchronization: scl and sda_in each pass through SYNC_STAGES flops, then one history flop for edge detection.
- START: synced SDA falls while synced SCL is high. Valid in any state, including mid-frame (repeated START).
- STOP: synced SDA rises while synced SCL is high.
- Data bits are sampled MSB first on synced SCL rising edges. sda_oe changes only on synced SCL falling edges, except on reset.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits.
    - Address match and R/W=0 → ACK_A.
    - Match and R/W=1 → NACK, nack_count+1, then IGNORE.
    - No match → IGNORE with SDA released. nack_count is unchanged.
  - ACK_A → BYTE1. BYTE1 holds reg_addr[6:0] and data[8]. → ACK_1.
  - ACK_1 → BYTE2. BYTE2 holds data[7:0]. → ACK_2.
  - ACK_2 → EXTRA.
  - EXTRA: any further 8 bits → NACK, nack_count+1, then IGNORE.
  - IGNORE: wait for START (→ ADDR) or STOP (→ IDLE).
  - STOP in any state → IDLE. START in any state → ADDR.
- Partial frames: a frame aborted by STOP or START before ACK_2 completes produces no write.
- ACK: on the SCL falling edge after the 8th bit, sda_oe goes to 1. On the next SCL falling edge, sda_oe goes to 0.
  - NACK holds sda_oe at 0 through the ninth clock.
- Write commit: happens at the SCL falling edge that ends ACK_2.
  - wr_valid=1 for exactly one clk.
  - wr_addr and wr_data update and hold until the next commit.
  - If reg_addr ≤ 0x0E, regs[reg_addr] ← data.
  - If reg_addr = 0x0F (codec reset register), all 16 registers clear to 0, regardless of data.
  - If reg_addr ≥ 0x10, the write is acknowledged and wr_valid pulses, but the register file is unchanged.
- nack_count saturates at 0xFF.
- rd_data ← regs[rd_addr] every clk.
  - A read in the commit cycle returns the old value. The new value is visible on the following cycle.

## Timing
- Reset values: sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, rd_data=0, nack_count=0, all regs=0, state=IDLE, synchronizers=1 (idle bus).
- Reset asserted mid-frame (including during ACK) sets sda_oe=0 on the next clk edge.
- Bus-to-event latency: SYNC_STAGES+1 clk from a pin transition to the START/STOP/bit/sda_oe action.
- Requirement: clk ≥ 8× SCL frequency, and SCL high/low phases ≥ SYNC_STAGES+2 clk.
- SDA hold after SCL falls must exceed the synchronizer latency so that a data change is not taken as START/STOP. The initiator meets this.
- busy rises SYNC_STAGES+1 clk after START and falls SYNC_STAGES+1 clk after STOP.

## Test plan
- Write 0x34, 0x08, 0x12, then STOP.
  - ACK on all 3 ninth clocks.
  - One wr_valid with wr_addr=0x04, wr_data=0x012.
  - rd_addr=4 → rd_data=0x012 two clk later.
- Address 0x36 (other device).
  - sda_oe stays 0 for the whole frame.
  - No wr_valid; nack_count=0; busy high until STOP.
- Address 0x35 (read) → NACK, nack_count=1, IGNORE until STOP. Then a valid write to reg 0x07 data 0x1FF → regs[7]=0x1FF.
- Load regs 4 and 7, then write 0x34, 0x1E, 0x00 (reg 0x0F).
  - wr_valid pulses.
  - rd_data for indices 4 and 7 reads 0x000.
- Two aborted frames, then a recovery frame:
  - 0x34, 0x08, then STOP → no wr_valid.
  - 0x34, 0x08, then repeated START, 0x34, 0x0A, 0x55 → wr_addr=0x05, wr_data=0x055.
  - A 4th data byte after that → NACK, nack_count+1.
- Assert reset during the ACK_1 low phase.
  - sda_oe=0 and all outputs at reset values next clk.
  - The next full frame completes normally.

Source files
------------

// File: rtl/i2c_codec_target.sv
// i2c_codec_target
// I2C target modelling a WM8731-style codec control port. Decodes 3-byte
// write frames (device address 0x34, reg_addr[6:0]/data[8], data[7:0]),
// acknowledges them, and mirrors the writes into a 16 x 9-bit shadow
// register file.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   scl, sda_in  asynchronous I2C bus inputs
//   sda_oe       1 = pull SDA low (open-drain)
//   busy         high between a detected START and the next STOP
//   wr_valid     one-clk pulse per committed register write
//   wr_addr      register address of the last write (held)
//   wr_data      data of the last write (held)
//   rd_addr      shadow register read index
//   rd_data      registered shadow register read data
//   nack_count   saturating count of NACKs issued
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic [7:0] nack_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1,
        S_BYTE2, S_ACK_2, S_EXTRA, S_NACK, S_IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start, stop;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] byte1;
    logic       byte_done, shifting;
    logic       oe_n, nack_inc, commit, latch_b1;
    logic [6:0] commit_addr;
    logic [8:0] regs [16];

    // Synchronizer plus history flop; resets to the idle-bus level
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    // SDA may only move while SCL is low; an SDA edge with SCL steady high is a bus condition
    assign start    = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop     = scl_s & scl_prev & ~sda_prev & sda_s;

    assign byte_done   = (bit_cnt == 4'd8);
    assign shifting    = (state == S_ADDR) || (state == S_BYTE1) ||
                         (state == S_BYTE2) || (state == S_EXTRA);
    assign commit_addr = byte1[7:1];

    // Next-state logic; every ACK/NACK decision is taken on an SCL falling edge
    always_comb begin
        state_n  = state;
        oe_n     = sda_oe;
        nack_inc = 1'b0;
        commit   = 1'b0;
        latch_b1 = 1'b0;
        if (start) begin
            state_n = S_ADDR;
        end else if (stop) begin
            state_n = S_IDLE;
        end else if (scl_fall) begin
            case (state)
                S_ADDR: if (byte_done) begin
                    if (shift[7:1] == DEV_ADDR) begin
                        if (!shift[0]) begin
                            state_n = S_ACK_A;
                            oe_n    = 1'b1;
                        end else begin
                            state_n  = S_NACK;
                            nack_inc = 1'b1;
                        end
                    end else begin
                        state_n = S_IGNORE;
                    end
                end
                S_ACK_A: begin
                    state_n = S_BYTE1;
                    oe_n    = 1'b0;
                end
                S_BYTE1: if (byte_done) begin
                    state_n  = S_ACK_1;
                    oe_n     = 1'b1;
                    latch_b1 = 1'b1;
                end
                S_ACK_1: begin
                    state_n = S_BYTE2;
                    oe_n    = 1'b0;
                end
                S_BYTE2: if (byte_done) begin
                    state_n = S_ACK_2;
                    oe_n    = 1'b1;
                end
                S_ACK_2: begin
                    state_n = S_EXTRA;
                    oe_n    = 1'b0;
                    commit  = 1'b1;
                end
                S_EXTRA: if (byte_done) begin
                    state_n  = S_NACK;
                    nack_inc = 1'b1;
                end
                S_NACK: state_n = S_IGNORE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            nack_count <= '0;
        end else begin
            state  <= state_n;
            sda_oe <= oe_n;
            if (start)
                busy <= 1'b1;
            else if (stop)
                busy <= 1'b0;
            // Counter restarts on every state change so each byte state begins at bit 0
            if (start || (state_n != state))
                bit_cnt <= '0;
            else if (scl_rise && shifting && !byte_done)
                bit_cnt <= bit_cnt + 4'd1;
            if (nack_inc && (nack_count != 8'hFF))
                nack_count <= nack_count + 8'd1;
        end
    end

    // Byte shifter; held through the ACK clock so byte 2 is still present at commit
    always_ff @(posedge clk) begin
        if (!start && scl_rise && shifting && !byte_done)
            shift <= {shift[6:0], sda_s};
        if (latch_b1)
            byte1 <= shift;
    end

    // Commit and shadow register file
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_data  <= '0;
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else begin
            wr_valid <= commit;
            rd_data  <= regs[rd_addr];
            if (commit) begin
                wr_addr <= commit_addr;
                wr_data <= {byte1[0], shift};
                if (commit_addr <= 7'h0E)
                    regs[byte1[4:1]] <= {byte1[0], shift};
                else if (commit_addr == 7'h0F)
                    for (int i = 0; i < 16; i++)
                        regs[i] <= '0;
            end
        end
    end

endmodule
